// File: rtl/axi4_lite_pkg.sv
// Shared types and response codes for the AXI4-Lite register slave.
package axi4_lite_pkg;

    // A: address bits, N: data bytes, I: ID bits, USE_PROT: reserved prot option.
    typedef struct packed {
        int A;
        int N;
        int I;
        bit USE_PROT;
    } axi4_lite_cfg_t;

    localparam logic [1:0] AXI4_LITE_OKAY   = 2'b00;
    localparam logic [1:0] AXI4_LITE_SLVERR = 2'b10;

endpackage

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register-file slave: NUM_REGS registers of N bytes each, with
// independent read and write paths, byte strobes and SLVERR for unmapped indices.
module axi4_lite_reg_slave
    import axi4_lite_pkg::*;
#(
    parameter axi4_lite_cfg_t CONFIG   = '{A: 8, N: 4, I: 1, USE_PROT: 0},
    parameter int             NUM_REGS = 8
) (
    input  logic                                       aclk,
    input  logic                                       aresetn,
    // write address channel
    input  logic [CONFIG.A-1:0]                        awaddr,
    input  logic [(CONFIG.I > 0 ? CONFIG.I : 1)-1:0]   awid,
    input  logic [2:0]                                 awprot,
    input  logic                                       awvalid,
    output logic                                       awready,
    // write data channel
    input  logic [8*CONFIG.N-1:0]                      wdata,
    input  logic [CONFIG.N-1:0]                        wstrb,
    input  logic                                       wvalid,
    output logic                                       wready,
    // write response channel
    output logic [(CONFIG.I > 0 ? CONFIG.I : 1)-1:0]   bid,
    output logic [1:0]                                 bresp,
    output logic                                       bvalid,
    input  logic                                       bready,
    // read address channel
    input  logic [CONFIG.A-1:0]                        araddr,
    input  logic [(CONFIG.I > 0 ? CONFIG.I : 1)-1:0]   arid,
    input  logic [2:0]                                 arprot,
    input  logic                                       arvalid,
    output logic                                       arready,
    // read data channel
    output logic [8*CONFIG.N-1:0]                      rdata,
    output logic [(CONFIG.I > 0 ? CONFIG.I : 1)-1:0]   rid,
    output logic [1:0]                                 rresp,
    output logic                                       rvalid,
    input  logic                                       rready,
    // register file view
    output logic [NUM_REGS*8*CONFIG.N-1:0]             reg_q,
    output logic [NUM_REGS-1:0]                        reg_wr
);

    localparam int NB  = CONFIG.N;
    localparam int DW  = 8 * CONFIG.N;
    localparam int OFF = $clog2(CONFIG.N);
    localparam int XW  = CONFIG.A - OFF;
    localparam int IW  = (CONFIG.I > 0) ? CONFIG.I : 1;

    localparam logic [0:0] WR_IDLE = 1'b0;
    localparam logic [0:0] WR_RESP = 1'b1;
    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_DATA = 1'b1;

    // Low while in reset and for the reset edge itself, so the ready
    // outputs come up one cycle after aresetn is first seen high.
    logic                run_reg;

    logic [0:0]          wr_state_reg;
    logic                aw_held_reg;
    logic [XW-1:0]       aw_idx_reg;
    logic [IW-1:0]       aw_id_reg;
    logic                w_held_reg;
    logic [DW-1:0]       w_data_reg;
    logic [NB-1:0]       w_strb_reg;
    logic [IW-1:0]       bid_reg;
    logic [1:0]          bresp_reg;

    logic [0:0]          rd_state_reg;
    logic [DW-1:0]       rdata_reg;
    logic [1:0]          rresp_reg;
    logic [IW-1:0]       rid_reg;

    logic [DW-1:0]       regs_reg  [NUM_REGS];
    logic [DW-1:0]       regs_next [NUM_REGS];
    logic [NUM_REGS-1:0] reg_wr_reg;

    logic                aw_fire;
    logic                w_fire;
    logic                ar_fire;
    logic                commit;
    logic [XW-1:0]       wr_idx;
    logic [IW-1:0]       wr_id;
    logic [DW-1:0]       wr_data;
    logic [NB-1:0]       wr_strb;
    logic [XW-1:0]       rd_idx;
    logic [NUM_REGS-1:0] wr_hit;
    logic [NUM_REGS-1:0] rd_hit;
    logic [NUM_REGS-1:0] wr_sel;
    logic [DW-1:0]       rd_val;

    // prot and the byte-offset address bits carry no meaning here
    logic unused_inputs;
    assign unused_inputs = ^{awprot, arprot, awaddr, araddr};

    assign awready = run_reg && (wr_state_reg == WR_IDLE) && !aw_held_reg;
    assign wready  = run_reg && (wr_state_reg == WR_IDLE) && !w_held_reg;
    assign arready = run_reg && (rd_state_reg == RD_IDLE);
    assign bvalid  = (wr_state_reg == WR_RESP);
    assign rvalid  = (rd_state_reg == RD_DATA);
    assign bresp   = bresp_reg;
    assign rresp   = rresp_reg;
    assign rdata   = rdata_reg;
    assign bid     = (CONFIG.I > 0) ? bid_reg : '0;
    assign rid     = (CONFIG.I > 0) ? rid_reg : '0;
    assign reg_wr  = reg_wr_reg;

    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign ar_fire = arvalid && arready;

    // A held beat takes precedence; otherwise the beat being accepted now is used.
    assign wr_idx  = aw_held_reg ? aw_idx_reg : awaddr[CONFIG.A-1:OFF];
    assign wr_id   = aw_held_reg ? aw_id_reg  : awid;
    assign wr_data = w_held_reg  ? w_data_reg : wdata;
    assign wr_strb = w_held_reg  ? w_strb_reg : wstrb;
    assign commit  = (aw_held_reg || aw_fire) && (w_held_reg || w_fire);
    assign rd_idx  = araddr[CONFIG.A-1:OFF];

    // Per-register index match; an index matching no register is out of range.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign wr_hit[gi] = (wr_idx == XW'(gi));
            assign rd_hit[gi] = (rd_idx == XW'(gi));
            assign wr_sel[gi] = commit && wr_hit[gi];
            assign reg_q[gi*DW +: DW] = regs_reg[gi];
        end
    endgenerate

    // Byte-strobe merge of the committed write into the selected register.
    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_next[k] = regs_reg[k];
            for (int b = 0; b < NB; b++) begin
                if (wr_sel[k] && wr_strb[b]) begin
                    regs_next[k][b*8 +: 8] = wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Read mux over the current (pre-write) register contents.
    always_comb begin
        rd_val = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_hit[k]) begin
                rd_val = regs_reg[k];
            end
        end
    end

    // Register storage and write-strobe pulses.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_reg[k] <= '0;
            end
            reg_wr_reg <= '0;
        end else begin
            regs_reg   <= regs_next;
            reg_wr_reg <= wr_sel & {NUM_REGS{|wr_strb}};
        end
    end

    // Write FSM: collect AW and W in any order, commit, then hold the response.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            run_reg      <= 1'b0;
            wr_state_reg <= WR_IDLE;
            aw_held_reg  <= 1'b0;
            aw_idx_reg   <= '0;
            aw_id_reg    <= '0;
            w_held_reg   <= 1'b0;
            w_data_reg   <= '0;
            w_strb_reg   <= '0;
            bid_reg      <= '0;
            bresp_reg    <= AXI4_LITE_OKAY;
        end else begin
            run_reg <= 1'b1;
            if (wr_state_reg == WR_IDLE) begin
                if (commit) begin
                    wr_state_reg <= WR_RESP;
                    aw_held_reg  <= 1'b0;
                    w_held_reg   <= 1'b0;
                    bid_reg      <= wr_id;
                    bresp_reg    <= (|wr_hit) ? AXI4_LITE_OKAY : AXI4_LITE_SLVERR;
                end else begin
                    if (aw_fire) begin
                        aw_held_reg <= 1'b1;
                        aw_idx_reg  <= awaddr[CONFIG.A-1:OFF];
                        aw_id_reg   <= awid;
                    end
                    if (w_fire) begin
                        w_held_reg <= 1'b1;
                        w_data_reg <= wdata;
                        w_strb_reg <= wstrb;
                    end
                end
            end else if (bready) begin
                wr_state_reg <= WR_IDLE;
            end
        end
    end

    // Read FSM: register the data on the AR handshake, hold it until rready.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_state_reg <= RD_IDLE;
            rdata_reg    <= '0;
            rresp_reg    <= AXI4_LITE_OKAY;
            rid_reg      <= '0;
        end else if (rd_state_reg == RD_IDLE) begin
            if (ar_fire) begin
                rd_state_reg <= RD_DATA;
                rdata_reg    <= rd_val;
                rresp_reg    <= (|rd_hit) ? AXI4_LITE_OKAY : AXI4_LITE_SLVERR;
                rid_reg      <= arid;
            end
        end else if (rready) begin
            rd_state_reg <= RD_IDLE;
        end
    end

endmodule
